// File: rtl/md_unit_pkg.sv
// Shared opcodes, default cycle counts and op-class decode for the HI/LO unit.
// MD_MADD_EN adds madd/msub to the multiply class.
package md_unit_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'b000,
    MD_MULTU = 3'b001,
    MD_DIV   = 3'b010,
    MD_DIVU  = 3'b011,
    MD_MTHI  = 3'b100,
    MD_MTLO  = 3'b101,
    MD_MADD  = 3'b110,
    MD_MSUB  = 3'b111
  } md_op_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_e;

  localparam int unsigned MD_MULT_CYCLES_DEF = 5;
  localparam int unsigned MD_DIV_CYCLES_DEF  = 10;

  function automatic logic is_div_class(input md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_mul_class(input md_op_e op);
`ifdef MD_MADD_EN
    return (op == MD_MULT) || (op == MD_MULTU) ||
           (op == MD_MADD) || (op == MD_MSUB);
`else
    return (op == MD_MULT) || (op == MD_MULTU);
`endif
  endfunction

endpackage

// File: rtl/md_unit_if.sv
// Execute <-> multiply/divide handshake: operands, op, start/flush in;
// Busy and architectural HI/LO out.
interface md_unit_if;
  logic        flush;
  logic        start;
  logic [2:0]  mult_div_op;
  logic [31:0] D1;
  logic [31:0] D2;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output flush, start, mult_div_op, D1, D2,
    input  Busy, HI, LO
  );

  modport slave (
    input  flush, start, mult_div_op, D1, D2,
    output Busy, HI, LO
  );
endinterface

// File: rtl/md_div32.sv
// Combinational 32-bit divider; quotient truncates toward zero and the
// remainder takes the dividend's sign. div0_o flags a zero divisor.
module md_div32 (
    input  logic        sgn_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] quo_o,
    output logic [31:0] rem_o,
    output logic        div0_o
);

  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] b_den;
  logic [31:0] q_mag;
  logic [31:0] r_mag;

  assign a_neg  = sgn_i & a_i[31];
  assign b_neg  = sgn_i & b_i[31];
  assign a_mag  = a_neg ? -a_i : a_i;
  assign b_mag  = b_neg ? -b_i : b_i;
  assign div0_o = (b_i == 32'd0);

  // Keep the divide defined on a zero divisor; the result is discarded.
  assign b_den = div0_o ? 32'd1 : b_mag;
  assign q_mag = a_mag / b_den;
  assign r_mag = a_mag % b_den;

  // 0x80000000 / -1 wraps back to 0x80000000 through the negation.
  assign quo_o = (a_neg ^ b_neg) ? -q_mag : q_mag;
  assign rem_o = a_neg ? -r_mag : r_mag;

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO behind a start/Busy handshake.
// Define MD_MADD_EN to enable madd/msub accumulation into {HI,LO}.
module md_unit
  import md_unit_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input logic clk,
    input logic reset,
    md_unit_if.slave md
);

  localparam int unsigned MAXC =
    (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);

  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t MULT_N = cnt_t'(MULT_CYCLES);
  localparam cnt_t DIV_N  = cnt_t'(DIV_CYCLES);

  md_state_e   state_q, state_d;
  cnt_t        cnt_q, cnt_d;
  logic [63:0] pend_q, pend_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  md_op_e      op;
  logic        accept;
  logic        msgn;
  logic signed [32:0] ma;
  logic signed [32:0] mb;
  logic [63:0] prod;
  logic [63:0] mul_res;
  logic [31:0] quo;
  logic [31:0] rem;
  logic        div0;

  assign op     = md_op_e'(md.mult_div_op);
  assign accept = md.start & ~md.flush & (state_q == MD_IDLE);

  // Only multu treats its operands as unsigned.
  assign msgn = (op != MD_MULTU);
  assign ma   = {msgn & md.D1[31], md.D1};
  assign mb   = {msgn & md.D2[31], md.D2};
  assign prod = 64'(ma * mb);

`ifdef MD_MADD_EN
  always_comb begin
    mul_res = prod;
    unique case (1'b1)
      op == MD_MADD: mul_res = {hi_q, lo_q} + prod;
      op == MD_MSUB: mul_res = {hi_q, lo_q} - prod;
      default:       mul_res = prod;
    endcase
  end
`else
  assign mul_res = prod;
`endif

  md_div32 u_div (
    .sgn_i  (op == MD_DIV),
    .a_i    (md.D1),
    .b_i    (md.D2),
    .quo_o  (quo),
    .rem_o  (rem),
    .div0_o (div0)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      MD_IDLE: begin
        if (accept) begin
          unique case (1'b1)
            is_mul_class(op): begin
              state_d = MD_RUN;
              cnt_d   = MULT_N;
              pend_d  = mul_res;
            end
            is_div_class(op): begin
              state_d = MD_RUN;
              cnt_d   = DIV_N;
              // HI/LO cannot move during RUN, so this commits as a no-op.
              pend_d  = div0 ? {hi_q, lo_q} : {rem, quo};
            end
            op == MD_MTHI: hi_d = md.D1;
            op == MD_MTLO: lo_d = md.D1;
            default: ;
          endcase
        end
      end
      MD_RUN: begin
        cnt_d = cnt_q - cnt_t'(1);
        if (cnt_q == cnt_t'(1)) begin
          state_d      = MD_IDLE;
          {hi_d, lo_d} = pend_q;
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign md.Busy = (cnt_q != '0);
  assign md.HI   = hi_q;
  assign md.LO   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed corner cases plus random ops
// against a plain-arithmetic HI/LO model.
module tb_md_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic clk = 1'b0;
  logic reset;
  md_unit_if mif ();

  md_unit #(
    .MULT_CYCLES (MC),
    .DIV_CYCLES  (DC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .md    (mif)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [31:0] hi_m;
  logic [31:0] lo_m;

  function automatic int exp_cycles(input logic [2:0] op);
    case (op)
      3'd0, 3'd1: return MC;
      3'd2, 3'd3: return DC;
`ifdef MD_MADD_EN
      3'd6, 3'd7: return MC;
`endif
      default: return 0;
    endcase
  endfunction

  task automatic model_apply(input logic [2:0] op,
                             input logic [31:0] a,
                             input logic [31:0] b);
    longint sa, sb, sq, sr;
    logic [63:0] up, acc;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    up = {32'd0, a} * {32'd0, b};
    acc = {hi_m, lo_m};
    case (op)
      3'd0: {hi_m, lo_m} = 64'(sa * sb);
      3'd1: {hi_m, lo_m} = up;
      3'd2: if (b != 0) begin
        sq = sa / sb;
        sr = sa % sb;
        lo_m = sq[31:0];
        hi_m = sr[31:0];
      end
      3'd3: if (b != 0) begin
        lo_m = a / b;
        hi_m = a % b;
      end
      3'd4: hi_m = a;
      3'd5: lo_m = a;
`ifdef MD_MADD_EN
      3'd6: {hi_m, lo_m} = acc + 64'(sa * sb);
      3'd7: {hi_m, lo_m} = acc - 64'(sa * sb);
`endif
      default: ;
    endcase
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic fl);
    @(negedge clk);
    mif.mult_div_op = op;
    mif.D1 = a;
    mif.D2 = b;
    mif.start = 1'b1;
    mif.flush = fl;
    @(negedge clk);
    mif.start = 1'b0;
    mif.flush = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (mif.Busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    hi_m = 0;
    lo_m = 0;
    total += 3;
    if (mif.Busy !== 1'b0) begin
      bad++; $display("FAIL reset_busy got=%b exp=0", mif.Busy);
    end
    if (mif.HI !== 32'd0) begin
      bad++; $display("FAIL reset_hi got=%h exp=0", mif.HI);
    end
    if (mif.LO !== 32'd0) begin
      bad++; $display("FAIL reset_lo got=%h exp=0", mif.LO);
    end
  endtask

  task automatic test_mult;
    int n;
    issue(3'd0, 32'hFFFFFFFE, 32'd3, 1'b0);
    total += 2;
    if (mif.Busy !== 1'b1) begin
      bad++; $display("FAIL mult_busy got=%b exp=1", mif.Busy);
    end
    if (mif.LO !== lo_m) begin
      bad++; $display("FAIL mult_old_lo got=%h exp=%h", mif.LO, lo_m);
    end
    wait_idle(n);
    model_apply(3'd0, 32'hFFFFFFFE, 32'd3);
    total += 3;
    if (n != MC) begin
      bad++; $display("FAIL mult_cycles got=%0d exp=%0d", n, MC);
    end
    if (mif.HI !== 32'hFFFFFFFF) begin
      bad++; $display("FAIL mult_hi got=%h exp=ffffffff", mif.HI);
    end
    if (mif.LO !== 32'hFFFFFFFA) begin
      bad++; $display("FAIL mult_lo got=%h exp=fffffffa", mif.LO);
    end
  endtask

  task automatic test_multu;
    int n;
    issue(3'd1, 32'hFFFFFFFE, 32'd3, 1'b0);
    wait_idle(n);
    model_apply(3'd1, 32'hFFFFFFFE, 32'd3);
    total += 3;
    if (n != MC) begin
      bad++; $display("FAIL multu_cycles got=%0d exp=%0d", n, MC);
    end
    if (mif.HI !== 32'h2) begin
      bad++; $display("FAIL multu_hi got=%h exp=00000002", mif.HI);
    end
    if (mif.LO !== 32'hFFFFFFFA) begin
      bad++; $display("FAIL multu_lo got=%h exp=fffffffa", mif.LO);
    end
  endtask

  task automatic test_div;
    int n;
    issue(3'd2, 32'hFFFFFFF9, 32'd2, 1'b0);
    wait_idle(n);
    model_apply(3'd2, 32'hFFFFFFF9, 32'd2);
    total += 3;
    if (n != DC) begin
      bad++; $display("FAIL div_cycles got=%0d exp=%0d", n, DC);
    end
    if (mif.LO !== 32'hFFFFFFFD) begin
      bad++; $display("FAIL div_lo got=%h exp=fffffffd", mif.LO);
    end
    if (mif.HI !== 32'hFFFFFFFF) begin
      bad++; $display("FAIL div_hi got=%h exp=ffffffff", mif.HI);
    end
  endtask

  task automatic test_div0;
    int n;
    issue(3'd3, 32'd7, 32'd0, 1'b0);
    wait_idle(n);
    model_apply(3'd3, 32'd7, 32'd0);
    total += 3;
    if (n != DC) begin
      bad++; $display("FAIL div0_cycles got=%0d exp=%0d", n, DC);
    end
    if (mif.HI !== 32'hFFFFFFFF) begin
      bad++; $display("FAIL div0_hi got=%h exp=ffffffff", mif.HI);
    end
    if (mif.LO !== 32'hFFFFFFFD) begin
      bad++; $display("FAIL div0_lo got=%h exp=fffffffd", mif.LO);
    end
  endtask

  task automatic test_overflow;
    int n;
    issue(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    wait_idle(n);
    model_apply(3'd2, 32'h80000000, 32'hFFFFFFFF);
    total += 2;
    if (mif.LO !== 32'h80000000) begin
      bad++; $display("FAIL ovf_lo got=%h exp=80000000", mif.LO);
    end
    if (mif.HI !== 32'h0) begin
      bad++; $display("FAIL ovf_hi got=%h exp=0", mif.HI);
    end
  endtask

  task automatic test_flush;
    logic [31:0] h0, l0;
    h0 = hi_m;
    l0 = lo_m;
    issue(3'd0, 32'd3, 32'd4, 1'b1);
    total += 1;
    if (mif.Busy !== 1'b0) begin
      bad++; $display("FAIL flush_busy got=%b exp=0", mif.Busy);
    end
    repeat (MC + 1) @(negedge clk);
    total += 2;
    if (mif.HI !== h0) begin
      bad++; $display("FAIL flush_hi got=%h exp=%h", mif.HI, h0);
    end
    if (mif.LO !== l0) begin
      bad++; $display("FAIL flush_lo got=%h exp=%h", mif.LO, l0);
    end
    issue(3'd4, 32'h1234, 32'd9, 1'b0);
    model_apply(3'd4, 32'h1234, 32'd9);
    total += 3;
    if (mif.HI !== 32'h1234) begin
      bad++; $display("FAIL mthi_hi got=%h exp=00001234", mif.HI);
    end
    if (mif.Busy !== 1'b0) begin
      bad++; $display("FAIL mthi_busy got=%b exp=0", mif.Busy);
    end
    if (mif.LO !== l0) begin
      bad++; $display("FAIL mthi_lo got=%h exp=%h", mif.LO, l0);
    end
  endtask

  task automatic test_back_to_back;
    int n;
    issue(3'd1, 32'd6, 32'd7, 1'b0);
    mif.mult_div_op = 3'd3;
    mif.D1 = 32'd9;
    mif.D2 = 32'd2;
    mif.start = 1'b1;
    @(negedge clk);
    mif.start = 1'b0;
    wait_idle(n);
    model_apply(3'd1, 32'd6, 32'd7);
    total += 3;
    if (n + 1 != MC) begin
      bad++; $display("FAIL b2b_cycles got=%0d exp=%0d", n + 1, MC);
    end
    if (mif.LO !== 32'd42) begin
      bad++; $display("FAIL b2b_lo got=%h exp=0000002a", mif.LO);
    end
    if (mif.HI !== 32'd0) begin
      bad++; $display("FAIL b2b_hi got=%h exp=0", mif.HI);
    end
    @(negedge clk);
    total += 1;
    if (mif.Busy !== 1'b0) begin
      bad++; $display("FAIL b2b_idle got=%b exp=0", mif.Busy);
    end
  endtask

  task automatic test_random;
    int n;
    logic [2:0] op;
    logic [31:0] a, b;
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'hFFFFFFFF;
        2: a = 32'h80000000;
        3: b = 32'($urandom_range(1, 9));
        default: ;
      endcase
      issue(op, a, b, 1'b0);
      wait_idle(n);
      model_apply(op, a, b);
      total += 3;
      if (n != exp_cycles(op)) begin
        bad++;
        $display("FAIL rnd_cycles op=%0d got=%0d exp=%0d",
                 op, n, exp_cycles(op));
      end
      if (mif.HI !== hi_m) begin
        bad++;
        $display("FAIL rnd_hi op=%0d a=%h b=%h got=%h exp=%h",
                 op, a, b, mif.HI, hi_m);
      end
      if (mif.LO !== lo_m) begin
        bad++;
        $display("FAIL rnd_lo op=%0d a=%h b=%h got=%h exp=%h",
                 op, a, b, mif.LO, lo_m);
      end
    end
  endtask

  task automatic test_reset_mid;
    issue(3'd2, 32'd100, 32'd7, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    hi_m = 0;
    lo_m = 0;
    total += 3;
    if (mif.Busy !== 1'b0) begin
      bad++; $display("FAIL rmid_busy got=%b exp=0", mif.Busy);
    end
    if (mif.HI !== 32'd0) begin
      bad++; $display("FAIL rmid_hi got=%h exp=0", mif.HI);
    end
    if (mif.LO !== 32'd0) begin
      bad++; $display("FAIL rmid_lo got=%h exp=0", mif.LO);
    end
    repeat (DC + 3) @(negedge clk);
    total += 2;
    if (mif.LO !== 32'd0) begin
      bad++; $display("FAIL rmid_late_lo got=%h exp=0", mif.LO);
    end
    if (mif.Busy !== 1'b0) begin
      bad++; $display("FAIL rmid_late_busy got=%b exp=0", mif.Busy);
    end
  endtask

  task automatic test_madd;
    int n;
    issue(3'd4, 32'd0, 32'd0, 1'b0);
    issue(3'd5, 32'd5, 32'd0, 1'b0);
    model_apply(3'd4, 32'd0, 32'd0);
    model_apply(3'd5, 32'd5, 32'd0);
    issue(3'd6, 32'd2, 32'd3, 1'b0);
    wait_idle(n);
    model_apply(3'd6, 32'd2, 32'd3);
`ifdef MD_MADD_EN
    total += 3;
    if (n != MC) begin
      bad++; $display("FAIL madd_cycles got=%0d exp=%0d", n, MC);
    end
    if (mif.LO !== 32'd11) begin
      bad++; $display("FAIL madd_lo got=%h exp=0000000b", mif.LO);
    end
    if (mif.HI !== 32'd0) begin
      bad++; $display("FAIL madd_hi got=%h exp=0", mif.HI);
    end
    issue(3'd7, 32'd4, 32'd5, 1'b0);
    wait_idle(n);
    model_apply(3'd7, 32'd4, 32'd5);
    total += 2;
    if (mif.HI !== 32'hFFFFFFFF) begin
      bad++; $display("FAIL msub_hi got=%h exp=ffffffff", mif.HI);
    end
    if (mif.LO !== 32'hFFFFFFF7) begin
      bad++; $display("FAIL msub_lo got=%h exp=fffffff7", mif.LO);
    end
`else
    total += 3;
    if (n != 0) begin
      bad++; $display("FAIL madd_nop_cycles got=%0d exp=0", n);
    end
    if (mif.LO !== 32'd5) begin
      bad++; $display("FAIL madd_nop_lo got=%h exp=00000005", mif.LO);
    end
    if (mif.HI !== 32'd0) begin
      bad++; $display("FAIL madd_nop_hi got=%h exp=0", mif.HI);
    end
`endif
  endtask

  initial begin
    reset = 1'b1;
    mif.start = 1'b0;
    mif.flush = 1'b0;
    mif.mult_div_op = 3'd0;
    mif.D1 = 32'd0;
    mif.D2 = 32'd0;
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_div0();
    test_overflow();
    test_flush();
    test_back_to_back();
    test_madd();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
